// File: rtl/bht_predictor.sv
// Branch predictor: tagged BTB plus saturating-counter history table, with IF-stage
// next-PC prediction, EX-stage mispredict/redirect resolution and branch statistics.
module bht_predictor #(
    parameter int ENTRIES  = 64,
    parameter int CNT_BITS = 2,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    output logic        ready_o,
    input  logic [31:0] pc_f,
    output logic        pred_hit_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_npc_f,
    input  logic        upd_valid_e,
    input  logic [31:0] upd_pc_e,
    input  logic        upd_taken_e,
    input  logic [31:0] upd_target_e,
    input  logic        upd_pred_taken_e,
    input  logic [31:0] upd_pred_npc_e,
    output logic        mispred_e,
    output logic [31:0] redirect_pc_e,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int                  IDX     = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] WT      = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] WNT     = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [IDX-1:0]      LAST    = IDX'(ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [IDX-1:0]  walk_q, walk_d;
    logic [31:0]     br_cnt_q, mispred_cnt_q;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

    // Prediction path
    logic [IDX-1:0]      f_idx;
    logic [TAG_BITS-1:0] f_tag;
    assign f_idx = pc_f[IDX+1:2];
    assign f_tag = pc_f[IDX+TAG_BITS+1:IDX+2];

    assign ready_o      = (state_q == RUN);
    assign pred_hit_f   = ready_o & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign pred_taken_f = pred_hit_f & cnt_q[f_idx][CNT_BITS-1];
    assign pred_npc_f   = pred_taken_f ? tgt_q[f_idx] : pc_f + 32'd4;

    // Resolve path, independent of table state
    logic [31:0] actual_npc;
    assign actual_npc    = upd_taken_e ? upd_target_e : upd_pc_e + 32'd4;
    assign mispred_e     = upd_valid_e & (actual_npc != upd_pred_npc_e);
    assign redirect_pc_e = actual_npc;

    logic [IDX-1:0]      u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;
    logic [CNT_BITS-1:0] u_cnt;
    assign u_idx = upd_pc_e[IDX+1:2];
    assign u_tag = upd_pc_e[IDX+TAG_BITS+1:IDX+2];
    assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
    assign u_cnt = cnt_q[u_idx];

    // FSM next state
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        walk_d  = walk_q;
        if (flush_i) begin
            state_d = INIT;
            walk_d  = '0;
        end else if (state_q == INIT) begin
            walk_d = walk_q + 1'b1;
            if (walk_q == LAST) state_d = RUN;
        end
    end

    // Single table write port shared by the init walk and training
    logic                wr_en;
    logic [IDX-1:0]      wr_idx;
    logic                wr_valid;
    logic [TAG_BITS-1:0] wr_tag;
    logic [31:0]         wr_tgt;
    logic [CNT_BITS-1:0] wr_cnt;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = u_idx;
        wr_valid = 1'b1;
        wr_tag   = u_tag;
        wr_tgt   = upd_target_e;
        wr_cnt   = WT;
        if (flush_i) begin
            wr_en = 1'b0;
        end else if (state_q == INIT) begin
            wr_en    = 1'b1;
            wr_idx   = walk_q;
            wr_valid = 1'b0;
            wr_tag   = '0;
            wr_tgt   = '0;
            wr_cnt   = WNT;
        end else if (upd_valid_e) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (upd_taken_e) begin
                    wr_cnt = (u_cnt == CNT_MAX) ? u_cnt : u_cnt + 1'b1;
                end else begin
                    wr_tgt = tgt_q[u_idx];
                    wr_cnt = (u_cnt == '0) ? u_cnt : u_cnt - 1'b1;
                end
            end else if (upd_taken_e) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q       <= INIT;
            walk_q        <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            if (upd_valid_e) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred_e) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    // NOTE: tables are not reset; the INIT walk clears them and ready_o gates every read meanwhile.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_tgt;
            cnt_q[wr_idx]   <= wr_cnt;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    // Bits outside index/tag and the carried prediction bit are intentionally ignored
    logic unused;
    assign unused = ^{pc_f, upd_pc_e, upd_pred_taken_e};

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed vector table, flush/reset sequences,
// and randomized traffic against an abstract table model.
module tb_bht_predictor;

    localparam int NUM  = 16;
    localparam int CMAX = 3;
    localparam int CWT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic [31:0] pc_f = 32'h0;
    logic        pred_hit_f, pred_taken_f;
    logic [31:0] pred_npc_f;
    logic        upd_valid_e = 1'b0;
    logic [31:0] upd_pc_e = 32'h0;
    logic        upd_taken_e = 1'b0;
    logic [31:0] upd_target_e = 32'h0;
    logic        upd_pred_taken_e = 1'b0;
    logic [31:0] upd_pred_npc_e = 32'h0;
    logic        mispred_e;
    logic [31:0] redirect_pc_e, br_cnt_o, mispred_cnt_o;

    bht_predictor #(.ENTRIES(16), .CNT_BITS(2), .TAG_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ready_o(ready_o),
        .pc_f(pc_f), .pred_hit_f(pred_hit_f), .pred_taken_f(pred_taken_f),
        .pred_npc_f(pred_npc_f), .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e),
        .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
        .upd_pred_taken_e(upd_pred_taken_e), .upd_pred_npc_e(upd_pred_npc_e),
        .mispred_e(mispred_e), .redirect_pc_e(redirect_pc_e),
        .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: a table of branch records, a countdown until service resumes, and tallies
    bit          m_valid [NUM];
    int unsigned m_tag   [NUM];
    logic [31:0] m_tgt   [NUM];
    int          m_cnt   [NUM];
    int          init_left;
    logic [31:0] m_br, m_mc;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % NUM);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / 64) % 256;
    endfunction

    task automatic model_pred(input logic [31:0] pc, output logic hit, output logic tk,
                              output logic [31:0] npc);
        int s;
        s   = slot_of(pc);
        hit = (init_left == 0) && m_valid[s] && (m_tag[s] == tag_of(pc));
        tk  = hit && (m_cnt[s] >= CWT);
        npc = tk ? m_tgt[s] : pc + 32'd4;
    endtask

    function automatic logic [31:0] model_actual();
        return upd_taken_e ? upd_target_e : upd_pc_e + 32'd4;
    endfunction

    function automatic logic model_mis();
        return upd_valid_e && (model_actual() != upd_pred_npc_e);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) m_valid[i] = 0;
        init_left = NUM;
        m_br = 0;
        m_mc = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        int s;
        logic hit, tk;
        logic [31:0] npc;
        if (upd_valid_e) m_br = m_br + 1;
        if (model_mis()) m_mc = m_mc + 1;
        if (flush_i) begin
            for (int i = 0; i < NUM; i++) m_valid[i] = 0;
            init_left = NUM;
        end else if (init_left > 0) begin
            init_left--;
        end else if (upd_valid_e) begin
            s = slot_of(upd_pc_e);
            hit = m_valid[s] && (m_tag[s] == tag_of(upd_pc_e));
            if (hit) begin
                if (upd_taken_e) begin
                    m_cnt[s] = (m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX;
                    m_tgt[s] = upd_target_e;
                end else begin
                    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                end
            end else if (upd_taken_e) begin
                m_valid[s] = 1;
                m_tag[s]   = tag_of(upd_pc_e);
                m_tgt[s]   = upd_target_e;
                m_cnt[s]   = CWT;
            end
        end
        model_pred(32'h0, hit, tk, npc);
    endtask

    task automatic compare_outputs(input string ph);
        logic hit, tk;
        logic [31:0] npc;
        model_pred(pc_f, hit, tk, npc);
        check({ph, "_ready"}, ready_o, init_left == 0);
        check({ph, "_hit"}, pred_hit_f, hit);
        check({ph, "_taken"}, pred_taken_f, tk);
        check({ph, "_npc"}, pred_npc_f, npc);
        check({ph, "_mispred"}, mispred_e, model_mis());
        check({ph, "_redirect"}, redirect_pc_e, model_actual());
        check({ph, "_br_cnt"}, br_cnt_o, m_br);
        check({ph, "_mis_cnt"}, mispred_cnt_o, m_mc);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic uv, input logic [31:0] upc, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pnpc);
        upd_valid_e      = uv;
        upd_pc_e         = upc;
        upd_taken_e      = tk;
        upd_target_e     = tgt;
        upd_pred_npc_e   = pnpc;
        upd_pred_taken_e = (pnpc != upc + 32'd4);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 63) << 2);
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] pnpc;
        logic        hit;
        logic        ptk;
        logic [31:0] npc;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] br;
        logic [31:0] mc;
    } vec_t;

    vec_t vq[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // pc_f,  uv, upc,  tk, tgt,  pnpc,  hit ptk npc   mis redir br mc
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 32'h104, 0, 32'h4,   0,  0});
        vq.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  32'h104, 0, 0, 32'h104, 1, 32'h80,  0,  0});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   1, 1, 32'h80,  0, 32'h4,   1,  1});
        vq.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  32'h80,  1, 1, 32'h80,  0, 32'h80,  1,  1});
        vq.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  32'h80,  1, 1, 32'h80,  0, 32'h80,  2,  1});
        vq.push_back('{32'h100, 1, 32'h100, 0, 32'h80,  32'h80,  1, 1, 32'h80,  1, 32'h104, 3,  1});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   1, 1, 32'h80,  0, 32'h4,   4,  2});
        vq.push_back('{32'h100, 1, 32'h100, 0, 32'h80,  32'h80,  1, 1, 32'h80,  1, 32'h104, 4,  2});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   1, 0, 32'h104, 0, 32'h4,   5,  3});
        vq.push_back('{32'h140, 0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 32'h144, 0, 32'h4,   5,  3});
        vq.push_back('{32'h140, 1, 32'h140, 0, 32'h300, 32'h144, 0, 0, 32'h144, 0, 32'h144, 5,  3});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   1, 0, 32'h104, 0, 32'h4,   6,  3});
        vq.push_back('{32'h100, 1, 32'h140, 1, 32'h300, 32'h144, 1, 0, 32'h104, 1, 32'h300, 6,  3});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 32'h104, 0, 32'h4,   7,  4});
        vq.push_back('{32'h140, 0, 32'h0,   0, 32'h0,   32'h0,   1, 1, 32'h300, 0, 32'h4,   7,  4});
        vq.push_back('{32'h140, 1, 32'h140, 1, 32'h200, 32'h300, 1, 1, 32'h300, 1, 32'h200, 7,  4});
        vq.push_back('{32'h140, 0, 32'h0,   0, 32'h0,   32'h0,   1, 1, 32'h200, 0, 32'h4,   8,  5});
        vq.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  32'h104, 0, 0, 32'h104, 1, 32'h80,  8,  5});
        vq.push_back('{32'h100, 1, 32'h100, 1, 32'h200, 32'h80,  1, 1, 32'h80,  1, 32'h200, 9,  6});
        vq.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   32'h0,   1, 1, 32'h200, 0, 32'h4,   10, 7});
        vq.push_back('{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 10, 7});
        vq.push_back('{32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h4,   11, 7});

        // Reset state and the init walk
        model_reset();
        pc_f = 32'h100;
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_hit", pred_hit_f, 0);
        check("rst_npc", pred_npc_f, 32'h104);
        check("rst_br_cnt", br_cnt_o, 0);
        check("rst_mis_cnt", mispred_cnt_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NUM; i++) begin
            check($sformatf("init_ready_%0d", i), ready_o, 0);
            check($sformatf("init_hit_%0d", i), pred_hit_f, 0);
            cycle();
        end
        check("init_ready_rise", ready_o, 1);
        check("init_npc", pred_npc_f, 32'h104);
        check("init_br_cnt", br_cnt_o, 0);

        // Directed vector table
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            pc_f = v.pc;
            set_upd(v.uv, v.upc, v.tk, v.tgt, v.pnpc);
            #1;
            check($sformatf("v%0d_hit", i), pred_hit_f, v.hit);
            check($sformatf("v%0d_taken", i), pred_taken_f, v.ptk);
            check($sformatf("v%0d_npc", i), pred_npc_f, v.npc);
            check($sformatf("v%0d_mispred", i), mispred_e, v.mis);
            check($sformatf("v%0d_redirect", i), redirect_pc_e, v.redir);
            check($sformatf("v%0d_br_cnt", i), br_cnt_o, v.br);
            check($sformatf("v%0d_mis_cnt", i), mispred_cnt_o, v.mc);
            cycle();
        end

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 500; i++) begin
            logic h, t;
            logic [31:0] n, upc, tgt;
            flush_i = ($urandom_range(0, 99) == 0);
            pc_f = rand_pc();
            upc = rand_pc();
            tgt = 32'h2000 + 32'($urandom_range(0, 255) << 2);
            model_pred(upc, h, t, n);
            if ($urandom_range(0, 3) != 0) begin
                set_upd($urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)), tgt, n);
            end else begin
                set_upd(1'b1, upc, 1'($urandom_range(0, 1)), tgt, upc + 32'd4);
            end
            #1;
            compare_outputs("rnd");
            cycle();
        end
        flush_i = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        while (init_left > 0) cycle();

        // Make sure 0x100 is resident, then flush and re-flush at walk index 5
        pc_f = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h104);
        #1;
        cycle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        check("pre_flush_hit", pred_hit_f, 1);
        flush_i = 1'b1;
        #1;
        compare_outputs("flush1");
        cycle();
        flush_i = 1'b0;
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h104);
        for (int i = 0; i < 5; i++) begin
            #1;
            compare_outputs("walk");
            cycle();
        end
        flush_i = 1'b1;
        #1;
        compare_outputs("flush2");
        cycle();
        flush_i = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            check($sformatf("reinit_ready_%0d", i), ready_o, 0);
            cycle();
        end
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        check("reinit_ready_rise", ready_o, 1);
        check("reinit_hit", pred_hit_f, 0);
        check("reinit_npc", pred_npc_f, 32'h104);
        check("reinit_br_kept", br_cnt_o, m_br);
        compare_outputs("post_flush");
        cycle();

        // Asynchronous reset mid-RUN
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h104);
        #1;
        cycle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ready", ready_o, 0);
        check("arst_br_cnt", br_cnt_o, 0);
        check("arst_mis_cnt", mispred_cnt_o, 0);
        check("arst_hit", pred_hit_f, 0);
        check("arst_npc", pred_npc_f, 32'h104);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            #1;
            compare_outputs("rerun");
            cycle();
        end
        check("rerun_ready", ready_o, 1);
        check("rerun_hit", pred_hit_f, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
